// File: rtl/polirv_pkg.sv
// Shared definitions for the memory arbiter: data widths, FSM states and
// the identity of the port that owns the shared memory.
package polirv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Round-robin decision between the instruction and data ports. Remembers
// which port was granted last and prefers the other one on a conflict.
module mem_arb_rr
  import polirv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_inst_req,
  input  logic   i_data_req,
  input  logic   i_take,
  output logic   o_any,
  output grant_e o_winner
);

  grant_e r_last;

  // Winner selection: a lone request wins, a conflict goes to the port not granted last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    o_any    = i_inst_req | i_data_req;
    o_winner = GNT_I;
    if (i_inst_req && i_data_req) begin
      o_winner = (r_last == GNT_D) ? GNT_I : GNT_D;
    end else if (i_data_req) begin
      o_winner = GNT_D;
    end
  end

  // Last-grant history, starting as "data" so instruction wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_last <= GNT_D;
    end else if (i_take) begin
      r_last <= o_winner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency memory between an instruction fetch port
// (32-bit words) and a data port (64-bit reads and writes). One transaction
// is in flight at a time; each lasts MEM_LAT cycles plus one ack cycle.
module mem_arbiter
  import polirv_pkg::*;
#(
  parameter int ADDR_BITS = 6,
  parameter int MEM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic [ILEN-1:0]      i_rdata,
  output logic                 i_ack,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [XLEN-1:0]      d_wdata,
  output logic [XLEN-1:0]      d_rdata,
  output logic                 d_ack,
  output logic [ADDR_BITS-1:0] m_addr,
  output logic                 m_we,
  output logic [XLEN-1:0]      m_wdata,
  input  logic [XLEN-1:0]      m_rdata,
  output logic                 busy
);

  // Counter value in the final grant cycle.
  localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

  arb_state_e           r_state;
  arb_state_e           w_next_state;
  logic [2:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_we;
  logic [XLEN-1:0]      r_wdata;
  logic                 r_i_hi;
  logic                 r_i_ack;
  logic                 r_d_ack;
  logic [ILEN-1:0]      r_i_rdata;
  logic [XLEN-1:0]      r_d_rdata;
  logic                 w_any;
  grant_e               w_winner;
  logic                 w_idle;
  logic                 w_take;
  logic                 w_done;
  logic                 w_unused;

  mem_arb_rr u_rr (
    .clk        (clk),
    .rst        (rst),
    .i_inst_req (i_req),
    .i_data_req (d_req),
    .i_take     (w_take),
    .o_any      (w_any),
    .o_winner   (w_winner)
  );

  assign w_idle = (r_state == ST_IDLE);
  assign w_take = w_idle && w_any;
  assign w_done = !w_idle && (r_cnt == LAST_CNT);

  // Sub-word address bits never reach the memory.
  assign w_unused = ^{i_addr[1:0], d_addr[2:0]};

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, busy flag and the single-cycle write strobe.
  always_comb begin
    w_next_state = r_state;
    busy         = !w_idle;
    m_we         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_next_state = (w_winner == GNT_D) ? ST_GRANT_D : ST_GRANT_I;
        end
      end
      ST_GRANT_I: begin
        if (w_done) w_next_state = ST_IDLE;
      end
      ST_GRANT_D: begin
        m_we = r_we && (r_cnt == 3'd0);
        if (w_done) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Grant-cycle counter: zero while idle, counts up through the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 3'd0;
    end else if (w_idle || w_done) begin
      r_cnt <= 3'd0;
    end else begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  // Capture the winner's request; these values drive the memory for the whole grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_i_hi  <= 1'b0;
    end else if (w_take) begin
      if (w_winner == GNT_D) begin
        r_addr  <= {d_addr[ADDR_BITS-1:3], 3'b000};
        r_we    <= d_we;
        r_wdata <= d_wdata;
      end else begin
        r_addr  <= {i_addr[ADDR_BITS-1:3], 3'b000};
        r_we    <= 1'b0;
        r_i_hi  <= i_addr[2];
      end
    end
  end

  // Register read data and raise the matching ack as the grant ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_ack <= w_done && (r_state == ST_GRANT_I);
      r_d_ack <= w_done && (r_state == ST_GRANT_D);
      if (w_done && (r_state == ST_GRANT_I)) begin
        r_i_rdata <= r_i_hi ? m_rdata[XLEN-1:ILEN] : m_rdata[ILEN-1:0];
      end
      if (w_done && (r_state == ST_GRANT_D) && !r_we) begin
        r_d_rdata <= m_rdata;
      end
    end
  end

  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign i_ack   = r_i_ack;
  assign d_ack   = r_d_ack;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each with
// its own 8-word memory model. Expected acks are queued when a request is
// driven and compared, in order and by cycle, when the acks appear.
module tb_mem_arbiter;

  localparam int AB = 6;

  typedef struct {
    logic        is_d;
    logic [63:0] data;
    int          ack_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          rst;
  logic [1:0]          i_req;
  logic [1:0][AB-1:0]  i_addr;
  logic [1:0][31:0]    i_rdata;
  logic [1:0]          i_ack;
  logic [1:0]          d_req;
  logic [1:0]          d_we;
  logic [1:0][AB-1:0]  d_addr;
  logic [1:0][63:0]    d_wdata;
  logic [1:0][63:0]    d_rdata;
  logic [1:0]          d_ack;
  logic [1:0][AB-1:0]  m_addr;
  logic [1:0]          m_we;
  logic [1:0][63:0]    m_wdata;
  logic [1:0][63:0]    m_rdata;
  logic [1:0]          busy;

  logic [63:0] mem [2][8];
  logic [1:0]  pre_en;
  logic [2:0]  pre_idx;
  logic [63:0] pre_dat;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   we_cnt [2];
  int   busy_cnt [2];
  exp_t sb0 [$];
  exp_t sb1 [$];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_arbiter #(.ADDR_BITS(AB), .MEM_LAT(k == 0 ? 1 : 3)) u_dut (
      .clk     (clk),
      .rst     (rst[k]),
      .i_req   (i_req[k]),
      .i_addr  (i_addr[k]),
      .i_rdata (i_rdata[k]),
      .i_ack   (i_ack[k]),
      .d_req   (d_req[k]),
      .d_we    (d_we[k]),
      .d_addr  (d_addr[k]),
      .d_wdata (d_wdata[k]),
      .d_rdata (d_rdata[k]),
      .d_ack   (d_ack[k]),
      .m_addr  (m_addr[k]),
      .m_we    (m_we[k]),
      .m_wdata (m_wdata[k]),
      .m_rdata (m_rdata[k]),
      .busy    (busy[k])
    );

    assign m_rdata[k] = mem[k][m_addr[k][5:3]];

    always @(posedge clk) begin
      if (pre_en[k]) mem[k][pre_idx] <= pre_dat;
      else if (m_we[k]) mem[k][m_addr[k][5:3]] <= m_wdata[k];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input exp_t e);
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Per-cycle monitor for one instance.
  task automatic mon(input int k);
    exp_t e;
    int   sz;
    if (m_we[k]) we_cnt[k]++;
    if (busy[k]) busy_cnt[k]++;
    if (i_ack[k] || d_ack[k]) begin
      check($sformatf("one_ack%0d", k), 64'(i_ack[k] & d_ack[k]), 64'd0);
      sz = (k == 0) ? sb0.size() : sb1.size();
      check($sformatf("ack_expected%0d", k), 64'(sz != 0), 64'd1);
      if (sz != 0) begin
        e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
        check($sformatf("ack_port%0d", k), 64'(d_ack[k]), 64'(e.is_d));
        check($sformatf("ack_cycle%0d", k), 64'(cyc), 64'(e.ack_cyc));
        if (e.is_d) check($sformatf("d_rdata%0d", k), d_rdata[k], e.data);
        else        check($sformatf("i_rdata%0d", k), 64'(i_rdata[k]), e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) mon(k);
  end

  task automatic preload(input int k, input logic [2:0] idx, input logic [63:0] dat);
    pre_idx   = idx;
    pre_dat   = dat;
    pre_en[k] = 1'b1;
    @(negedge clk);
    pre_en[k] = 1'b0;
  endtask

  task automatic check_reset(input int k);
    check($sformatf("rst_i_ack%0d", k), 64'(i_ack[k]), 64'd0);
    check($sformatf("rst_d_ack%0d", k), 64'(d_ack[k]), 64'd0);
    check($sformatf("rst_m_we%0d", k), 64'(m_we[k]), 64'd0);
    check($sformatf("rst_busy%0d", k), 64'(busy[k]), 64'd0);
    check($sformatf("rst_m_addr%0d", k), 64'(m_addr[k]), 64'd0);
    check($sformatf("rst_m_wdata%0d", k), m_wdata[k], 64'd0);
    check($sformatf("rst_i_rdata%0d", k), 64'(i_rdata[k]), 64'd0);
    check($sformatf("rst_d_rdata%0d", k), d_rdata[k], 64'd0);
  endtask

  // One request from a negedge while idle; returns at the ack negedge with the request dropped.
  task automatic do_req(input int k, input logic is_d, input logic we, input logic [AB-1:0] addr,
                        input logic [63:0] wdata, input logic [63:0] exp);
    int          lat = (k == 0) ? 1 : 3;
    logic [63:0] aligned = 64'({addr[AB-1:3], 3'b000});
    logic        seen = 1'b0;
    exp_t        e;
    if (is_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      i_req[k] = 1'b1; i_addr[k] = addr;
    end
    e.is_d = is_d; e.data = exp; e.ack_cyc = cyc + 1 + lat;
    push(k, e);
    @(negedge clk);
    check($sformatf("grant_m_addr%0d", k), 64'(m_addr[k]), aligned);
    check($sformatf("grant_busy%0d", k), 64'(busy[k]), 64'd1);
    for (int n = 0; n < 20 && !seen; n++) begin
      if (i_ack[k] || d_ack[k]) seen = 1'b1;
      else @(negedge clk);
    end
    check($sformatf("ack_seen%0d", k), 64'(seen), 64'd1);
    check($sformatf("idle_m_addr%0d", k), 64'(m_addr[k]), aligned);
    check($sformatf("idle_m_we%0d", k), 64'(m_we[k]), 64'd0);
    i_req[k] = 1'b0;
    d_req[k] = 1'b0;
  endtask

  initial begin
    int   we0;
    int   busy0;
    exp_t e;
    rst = 2'b11; i_req = '0; i_addr = '0; d_req = '0; d_we = '0; d_addr = '0; d_wdata = '0;
    pre_en = '0; pre_idx = '0; pre_dat = '0;
    we_cnt = '{0, 0}; busy_cnt = '{0, 0};
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    preload(0, 3'd1, 64'h1111_2222_3333_4444);
    preload(0, 3'd0, 64'hAAAA_BBBB_CCCC_DDDD);
    preload(1, 3'd4, 64'h0123_4567_89AB_CDEF);
    rst = 2'b00;
    @(negedge clk);

    // Fetch of the upper word of 0x08.
    do_req(0, 1'b0, 1'b0, 6'h0C, 64'd0, 64'h1111_2222);

    // Write then read back; d_rdata holds its old value at the write ack.
    we0 = we_cnt[0];
    do_req(0, 1'b1, 1'b1, 6'h10, 64'hDEAD_BEEF_0000_0001, 64'd0);
    check("write_strobe_cycles", 64'(we_cnt[0] - we0), 64'd1);
    do_req(0, 1'b1, 1'b0, 6'h10, 64'd0, 64'hDEAD_BEEF_0000_0001);

    // Address alignment: low bits dropped; bit 2 selects the fetch half.
    do_req(0, 1'b1, 1'b0, 6'h17, 64'd0, 64'hDEAD_BEEF_0000_0001);
    do_req(0, 1'b0, 1'b0, 6'h06, 64'd0, 64'hAAAA_BBBB);

    // Fresh reset, then both ports request together and hold: I, D, I, D.
    rst[0] = 1'b1;
    #1;
    check_reset(0);
    @(negedge clk);
    rst[0] = 1'b0;
    i_req[0] = 1'b1; i_addr[0] = 6'h08;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 6'h10;
    for (int n = 0; n < 4; n++) begin
      e.is_d    = n[0];
      e.data    = n[0] ? 64'hDEAD_BEEF_0000_0001 : 64'h3333_4444;
      e.ack_cyc = cyc + 2 + 2 * n;
      push(0, e);
    end
    repeat (8) @(negedge clk);
    i_req[0] = 1'b0;
    d_req[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("conflict_drained", 64'(sb0.size()), 64'd0);

    // MEM_LAT=3 read: busy for exactly three cycles.
    busy0 = busy_cnt[1];
    do_req(1, 1'b1, 1'b0, 6'h20, 64'd0, 64'h0123_4567_89AB_CDEF);
    check("busy_cycles_lat3", 64'(busy_cnt[1] - busy0), 64'd3);

    // Reset in the second grant cycle aborts the read; no ack may follow.
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 6'h20;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("pre_abort_busy", 64'(busy[1]), 64'd1);
    rst[1] = 1'b1;
    #1;
    check_reset(1);
    @(negedge clk);
    d_req[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_ack_d_rdata", d_rdata[1], 64'd0);

    // Recovery after the aborted transaction.
    do_req(1, 1'b0, 1'b0, 6'h24, 64'd0, 64'h0123_4567);
    repeat (2) @(negedge clk);
    check("sb0_empty", 64'(sb0.size()), 64'd0);
    check("sb1_empty", 64'(sb1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
